xc20xx_cfg_loader: RTL and testbench

XC20XX_CFG_LOADER -- requirements
Module: xc20xx_cfg_loader

---
 rtl/xc20xx_cfg_loader_pkg.sv | 22 ++
 rtl/xc20xx_cfg_defs.vh | 23 ++
 rtl/xc20xx_cfg_shreg.sv | 36 +++
 rtl/xc20xx_cfg_loader.sv | 161 ++++++++++++++++
 tb/tb_xc20xx_cfg_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xc20xx_cfg_loader_pkg.sv
// ============================================================
// Package : xc20xx_cfg_loader_pkg
// Brief   : shared constants and state type for the XC20xx loader
// Revision: 1.0
// ============================================================
`default_nettype none
package xc20xx_cfg_loader_pkg;
`include "xc20xx_cfg_defs.vh"

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_PRE    = c_ST_PRE,
        ST_LEN    = c_ST_LEN,
        ST_HDR    = c_ST_HDR,
        ST_FSTART = c_ST_FSTART,
        ST_FDATA  = c_ST_FDATA,
        ST_FSTOP  = c_ST_FSTOP,
        ST_DONE   = c_ST_DONE,
        ST_ERROR  = c_ST_ERROR
    } state_t;
endpackage
`default_nettype wire

// File: rtl/xc20xx_cfg_defs.vh
// ============================================================
// File    : xc20xx_cfg_defs.vh
// Brief   : state encodings and fixed bitstream fields for the XC20xx loader
// Revision: 1.0
// ============================================================
`default_nettype none
`ifndef XC20XX_CFG_DEFS_VH
`define XC20XX_CFG_DEFS_VH
localparam int         c_ST_W     = 4;
localparam logic [3:0] c_ST_IDLE   = 4'd0;
localparam logic [3:0] c_ST_PRE    = 4'd1;
localparam logic [3:0] c_ST_LEN    = 4'd2;
localparam logic [3:0] c_ST_HDR    = 4'd3;
localparam logic [3:0] c_ST_FSTART = 4'd4;
localparam logic [3:0] c_ST_FDATA  = 4'd5;
localparam logic [3:0] c_ST_FSTOP  = 4'd6;
localparam logic [3:0] c_ST_DONE   = 4'd7;
localparam logic [3:0] c_ST_ERROR  = 4'd8;
localparam logic [3:0] c_PREAMBLE  = 4'b0010;
localparam logic [3:0] c_HEADER    = 4'b1111;
localparam int         c_LEN_W     = 24;
`endif
`default_nettype wire

// File: rtl/xc20xx_cfg_shreg.sv
// ============================================================
// Module  : xc20xx_cfg_shreg
// Brief   : MSB-first frame shift register with wrapping bit counter
// Revision: 1.0
// ============================================================
`default_nettype none
module xc20xx_cfg_shreg #(
    parameter int FRAME_BITS = 46
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_shift,
    input  logic                  i_bit,
    output logic [FRAME_BITS-1:0] o_data,
    output logic                  o_last
);
    localparam int c_CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    logic [FRAME_BITS-1:0] r_data;
    logic [c_CNT_W-1:0]    r_cnt;

    // Counter wraps on the last bit so the next frame starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {r_data[FRAME_BITS-2:0], i_bit};
            r_cnt  <= o_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign o_data = r_data;
    assign o_last = (r_cnt == c_CNT_W'(FRAME_BITS - 1));
endmodule
`default_nettype wire

// File: rtl/xc20xx_cfg_loader.sv
// ============================================================
// Module  : xc20xx_cfg_loader
// Brief   : parses a serial XC20xx bitstream into addressed frame writes
// Revision: 1.0
// ============================================================
`default_nettype none
module xc20xx_cfg_loader
    import xc20xx_cfg_loader_pkg::*;
#(
    parameter int FRAME_BITS = 46,
    parameter int NUM_FRAMES = 160,
    parameter int ADDR_W     = 8
) (
    input  logic                  K,
    input  logic                  RST,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [ADDR_W-1:0]     FRAME_ADDR,
    output logic                  FRAME_WE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);
    state_t                r_state, w_state_nxt;
    logic [4:0]            r_step, w_step_nxt;
    logic [3:0]            r_ones;
    logic [c_LEN_W-1:0]    r_len, r_bitcnt;
    logic [ADDR_W-1:0]     r_idx, r_frame_addr;
    logic [FRAME_BITS-1:0] r_frame_data, w_sh_data;
    logic                  r_frame_we;
    logic                  w_shift, w_sh_last, w_write;
    logic                  w_last_frame, w_count_ok, w_counting;

    xc20xx_cfg_shreg #(.FRAME_BITS(FRAME_BITS)) u_shreg (
        .clk     (K),
        .rst     (RST),
        .i_shift (w_shift),
        .i_bit   (DIN),
        .o_data  (w_sh_data),
        .o_last  (w_sh_last)
    );

    assign w_last_frame = (r_idx == ADDR_W'(NUM_FRAMES - 1));
    // Includes the stop bit being consumed this cycle.
    assign w_count_ok   = ((r_bitcnt + c_LEN_W'(1)) == r_len);
    assign w_counting   = r_state inside {ST_PRE, ST_LEN, ST_HDR, ST_FSTART, ST_FDATA, ST_FSTOP};

    always_ff @(posedge K) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_shift     = 1'b0;
        w_write     = 1'b0;
        if (DIN_VALID) begin
            case (r_state)
                ST_IDLE: begin
                    if (DIN == c_PREAMBLE[3] && r_ones == 4'd8) begin
                        w_state_nxt = ST_PRE;
                        w_step_nxt  = '0;
                    end
                end
                ST_PRE: begin
                    if (DIN != c_PREAMBLE[2'd2 - r_step[1:0]]) begin
                        w_state_nxt = ST_ERROR;
                    end else if (r_step == 5'd2) begin
                        w_state_nxt = ST_LEN;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt  = r_step + 5'd1;
                    end
                end
                ST_LEN: begin
                    if (r_step == 5'(c_LEN_W - 1)) begin
                        w_state_nxt = ST_HDR;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt  = r_step + 5'd1;
                    end
                end
                ST_HDR: begin
                    if (DIN != c_HEADER[r_step[1:0]]) begin
                        w_state_nxt = ST_ERROR;
                    end else if (r_step == 5'd3) begin
                        w_state_nxt = ST_FSTART;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt  = r_step + 5'd1;
                    end
                end
                ST_FSTART: begin
                    w_state_nxt = DIN ? ST_ERROR : ST_FDATA;
                end
                ST_FDATA: begin
                    w_shift = 1'b1;
                    if (w_sh_last) begin
                        w_state_nxt = ST_FSTOP;
                        w_step_nxt  = '0;
                    end
                end
                ST_FSTOP: begin
                    if (!DIN) begin
                        w_state_nxt = ST_ERROR;
                    end else if (r_step == 5'd2) begin
                        w_write    = 1'b1;
                        w_step_nxt = '0;
                        if (!w_last_frame)   w_state_nxt = ST_FSTART;
                        else if (w_count_ok) w_state_nxt = ST_DONE;
                        else                 w_state_nxt = ST_ERROR;
                    end else begin
                        w_step_nxt = r_step + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge K) begin
        if (RST) begin
            r_step       <= '0;
            r_ones       <= '0;
            r_len        <= '0;
            r_bitcnt     <= '0;
            r_idx        <= '0;
            r_frame_data <= '0;
            r_frame_addr <= '0;
            r_frame_we   <= 1'b0;
        end else begin
            r_frame_we <= w_write;
            r_step     <= w_step_nxt;
            if (w_write) begin
                r_frame_data <= w_sh_data;
                r_frame_addr <= r_idx;
                if (!w_last_frame) r_idx <= r_idx + ADDR_W'(1);
            end
            if (DIN_VALID) begin
                if (r_state == ST_IDLE) begin
                    if (!DIN)                  r_ones <= '0;
                    else if (r_ones != 4'd8)   r_ones <= r_ones + 4'd1;
                end
                // The preamble's leading zero is the first counted bit.
                if (r_state == ST_IDLE && w_state_nxt == ST_PRE) r_bitcnt <= c_LEN_W'(1);
                else if (w_counting)                              r_bitcnt <= r_bitcnt + c_LEN_W'(1);
                if (r_state == ST_LEN) r_len <= {r_len[c_LEN_W-2:0], DIN};
            end
        end
    end

    assign FRAME_DATA = r_frame_data;
    assign FRAME_ADDR = r_frame_addr;
    assign FRAME_WE   = r_frame_we;
    assign BUSY       = !(r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign DONE       = (r_state == ST_DONE);
    assign ERR        = (r_state == ST_ERROR);
endmodule
`default_nettype wire

// File: tb/tb_xc20xx_cfg_loader.sv
// ============================================================
// Module  : tb_xc20xx_cfg_loader
// Brief   : randomized self-checking bench for xc20xx_cfg_loader
// Revision: 1.0
// ============================================================
`default_nettype none
module tb_xc20xx_cfg_loader;
    localparam int FB = 4;
    localparam int NF = 2;
    localparam int AW = 8;

    logic          K = 1'b0;
    logic          RST, DIN, DIN_VALID;
    logic [FB-1:0] FRAME_DATA;
    logic [AW-1:0] FRAME_ADDR;
    logic          FRAME_WE, BUSY, DONE, ERR;

    int n_vec = 0;
    int n_bad = 0;

    always #5 K = ~K;

    xc20xx_cfg_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
        .K          (K),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .FRAME_DATA (FRAME_DATA),
        .FRAME_ADDR (FRAME_ADDR),
        .FRAME_WE   (FRAME_WE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    bit            stream[$];
    int            m_pre_pos, m_end_pos, m_p;
    bit            m_end_done, m_stop;
    int            m_we_pos[$];
    logic [AW-1:0] m_we_addr[$];
    logic [FB-1:0] m_we_data[$];
    int            n_cons, obs_we;
    logic [AW-1:0] e_addr;
    logic [FB-1:0] e_data;

    task automatic push_bits(input int n, input logic [31:0] v);
        for (int k = n - 1; k >= 0; k--) stream.push_back(v[k]);
    endtask

    task automatic build_stream(input int len, input logic [3:0] pre,
                                input logic [FB*NF-1:0] fdata, input logic [3*NF-1:0] stops);
        stream.delete();
        push_bits(4, 32'b1110);
        push_bits(8, 32'hFF);
        push_bits(4, 32'(pre));
        push_bits(24, 32'(len));
        push_bits(4, 32'hF);
        for (int f = 0; f < NF; f++) begin
            push_bits(1, 32'd0);
            push_bits(FB, 32'(fdata[(NF-1-f)*FB +: FB]));
            push_bits(3, 32'(stops[(NF-1-f)*3 +: 3]));
        end
        push_bits(6, 32'b101101);
    endtask

    task automatic expect_field(input int n, input logic [31:0] want);
        for (int k = n - 1; k >= 0; k--) begin
            if (m_stop) return;
            if (m_p >= stream.size()) begin m_stop = 1; return; end
            if (stream[m_p] != want[k]) begin
                m_end_pos = m_p; m_end_done = 0; m_stop = 1; return;
            end
            m_p++;
        end
    endtask

    task automatic read_field(input int n, output logic [31:0] val);
        val = '0;
        for (int k = 0; k < n; k++) begin
            if (m_stop) return;
            if (m_p >= stream.size()) begin m_stop = 1; return; end
            val = {val[30:0], stream[m_p]};
            m_p++;
        end
    endtask

    // Reference parse of the whole stream: where the load starts, every write and the final verdict.
    task automatic model_parse();
        int          ones;
        logic [31:0] len, d;
        ones = 0;
        m_pre_pos = -1; m_end_pos = -1; m_end_done = 0; m_stop = 0; m_p = 0;
        m_we_pos.delete(); m_we_addr.delete(); m_we_data.delete();
        while (m_p < stream.size() && !(stream[m_p] == 1'b0 && ones == 8)) begin
            if (stream[m_p]) ones = (ones < 8) ? ones + 1 : 8;
            else             ones = 0;
            m_p++;
        end
        if (m_p >= stream.size()) return;
        m_pre_pos = m_p;
        m_p++;
        expect_field(3, 32'b010);
        read_field(24, len);
        expect_field(4, 32'hF);
        for (int f = 0; f < NF; f++) begin
            expect_field(1, 32'd0);
            read_field(FB, d);
            expect_field(3, 32'b111);
            if (m_stop) return;
            m_we_pos.push_back(m_p - 1);
            m_we_addr.push_back(AW'(f));
            m_we_data.push_back(FB'(d));
        end
        m_end_pos  = m_p - 1;
        m_end_done = ((m_p - m_pre_pos) == int'(len));
    endtask

    task automatic step(input bit v, input bit b);
        logic [AW+FB+3:0] got, exp;
        bit we_e, done_e, err_e, busy_e;
        @(negedge K);
        DIN_VALID = v;
        DIN       = b;
        @(posedge K);
        #1;
        we_e = 0;
        if (v) begin
            n_cons++;
            foreach (m_we_pos[i]) begin
                if (m_we_pos[i] == n_cons - 1) begin
                    we_e = 1; e_addr = m_we_addr[i]; e_data = m_we_data[i];
                end
            end
        end
        done_e = (m_end_pos >= 0) && m_end_done && (n_cons > m_end_pos);
        err_e  = (m_end_pos >= 0) && !m_end_done && (n_cons > m_end_pos);
        busy_e = (m_pre_pos >= 0) && (n_cons > m_pre_pos) && !done_e && !err_e;
        exp = {we_e, done_e, err_e, busy_e, e_addr, e_data};
        got = {FRAME_WE, DONE, ERR, BUSY, FRAME_ADDR, FRAME_DATA};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL outputs after bit %0d: got we=%b done=%b err=%b busy=%b addr=%0d data=%h, want we=%b done=%b err=%b busy=%b addr=%0d data=%h",
                     n_cons, FRAME_WE, DONE, ERR, BUSY, FRAME_ADDR, FRAME_DATA,
                     we_e, done_e, err_e, busy_e, e_addr, e_data);
        end
        if (FRAME_WE === 1'b1) obs_we++;
    endtask

    task automatic run_stream(input int limit, input int pct);
        int idx, budget;
        bit v;
        idx = 0;
        budget = limit * 20 + 50;
        while (idx < limit) begin
            v = ($urandom_range(99) < pct);
            step(v, v ? stream[idx] : bit'($urandom_range(1)));
            if (v) idx++;
            budget--;
            if (budget == 0) begin
                n_vec++; n_bad++;
                $display("FAIL stream_budget: consumed %0d of %0d bits", idx, limit);
                return;
            end
        end
        repeat (3) step(1'b0, bit'($urandom_range(1)));
    endtask

    task automatic do_reset(input int cycles);
        logic [AW+FB+3:0] got;
        for (int c = 0; c < cycles; c++) begin
            @(negedge K);
            RST = 1'b1; DIN_VALID = 1'b1; DIN = bit'($urandom_range(1));
            @(posedge K);
            #1;
            got = {FRAME_WE, DONE, ERR, BUSY, FRAME_ADDR, FRAME_DATA};
            n_vec++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL reset_state: got we=%b done=%b err=%b busy=%b addr=%0d data=%h, want all zero",
                         FRAME_WE, DONE, ERR, BUSY, FRAME_ADDR, FRAME_DATA);
            end
        end
        @(negedge K);
        RST = 1'b0; DIN_VALID = 1'b0;
        n_cons = 0; obs_we = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic check_end(input string name, input bit done_w, input bit err_w, input int we_w);
        n_vec++;
        if (DONE !== done_w || ERR !== err_w || obs_we != we_w) begin
            n_bad++;
            $display("FAIL %s: got done=%b err=%b strobes=%0d, want done=%b err=%b strobes=%0d",
                     name, DONE, ERR, obs_we, done_w, err_w, we_w);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        m_pre_pos = -1; m_end_pos = -1; m_we_pos.delete();
        repeat (2) step(1'b0, 1'b1);
    endtask

    task automatic test_valid_stream();
        do_reset(1);
        build_stream(48, 4'b0010, {4'hA, 4'h6}, 6'b111111);
        model_parse();
        run_stream(stream.size(), 100);
        check_end("valid_stream", 1'b1, 1'b0, 2);
    endtask

    task automatic test_bad_length();
        do_reset(1);
        build_stream(47, 4'b0010, {4'hA, 4'h6}, 6'b111111);
        model_parse();
        run_stream(stream.size(), 100);
        check_end("bad_length", 1'b0, 1'b1, 2);
    endtask

    task automatic test_bad_preamble();
        do_reset(1);
        build_stream(48, 4'b0011, {4'hA, 4'h6}, 6'b111111);
        model_parse();
        run_stream(stream.size(), 100);
        check_end("bad_preamble", 1'b0, 1'b1, 0);
    endtask

    task automatic test_bad_stop();
        do_reset(1);
        build_stream(48, 4'b0010, {4'hA, 4'h6}, 6'b111101);
        model_parse();
        run_stream(stream.size(), 100);
        check_end("bad_stop", 1'b0, 1'b1, 1);
    endtask

    task automatic test_valid_gaps();
        do_reset(1);
        build_stream(48, 4'b0010, {4'hA, 4'h6}, 6'b111111);
        model_parse();
        run_stream(stream.size(), 45);
        check_end("valid_gaps", 1'b1, 1'b0, 2);
    endtask

    task automatic test_reset_mid_frame();
        int cut;
        do_reset(1);
        build_stream(48, 4'b0010, {4'h3, 4'hC}, 6'b111111);
        model_parse();
        cut = m_we_pos[0] + 3;
        run_stream(cut, 70);
        do_reset(2);
        model_parse();
        run_stream(stream.size(), 70);
        check_end("reset_mid_frame", 1'b1, 1'b0, 2);
    endtask

    task automatic test_random();
        logic [FB*NF-1:0] fd;
        int len, pos;
        for (int it = 0; it < 12; it++) begin
            do_reset(1);
            fd  = (FB*NF)'($urandom);
            len = 48;
            if ($urandom_range(3) == 0) len = $urandom_range(1) ? 49 : 47;
            build_stream(len, 4'b0010, fd, 6'b111111);
            if ($urandom_range(3) == 0) begin
                pos = $urandom_range(stream.size() - 1);
                stream[pos] = !stream[pos];
            end
            model_parse();
            run_stream(stream.size(), $urandom_range(100, 30));
        end
    endtask

    initial begin
        RST = 1'b1; DIN = 1'b0; DIN_VALID = 1'b0;
        n_cons = 0; obs_we = 0; e_addr = '0; e_data = '0;
        test_reset();
        test_valid_stream();
        test_bad_length();
        test_bad_preamble();
        test_bad_stop();
        test_valid_gaps();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
